dmem_responder: RTL and testbench

Data-memory responder that sits on the memory side of the core's load/store port and replaces the bare block RAM. It accepts one request at a time through a req/ready handshake and inserts a configurable number of wait states. It performs byte, halfword and word accesses with MIPS-style little-endian lane selection and load sign/zero extension. Misaligned and out-of-range accesses complete with an error flag and do not modify memory.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with req/ready handshake, wait states,
// little-endian byte/half/word lanes, load extension and error reporting.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous reset, active-low
//   req    - request valid, held with its fields until ready
//   we     - 1 = store, 0 = load
//   size   - 00 byte, 01 half, 10 word, 11 illegal
//   unsgn  - zero-extend byte/half loads when 1
//   addr   - byte address
//   wdata  - right-aligned store data
//   rdata  - load result, valid while ready=1
//   ready  - one-cycle completion pulse
//   err    - error flag, valid while ready=1
module dmem_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsgn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d, unsgn_q, unsgn_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d, err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic          op_we, op_unsgn;
    logic [1:0]    op_size;
    logic [31:0]   op_addr, op_wdata;
    logic          commit, bad, wr_en;
    logic [AW-1:0] idx;
    logic [31:0]   cur, shifted, load_val, wrep;
    logic [3:0]    be;

    always_comb begin
        // With no wait states the commit edge is the accepting edge, so the
        // operation is decoded straight from the inputs while still in IDLE.
        op_we    = (state_q == IDLE) ? we    : we_q;
        op_size  = (state_q == IDLE) ? size  : size_q;
        op_unsgn = (state_q == IDLE) ? unsgn : unsgn_q;
        op_addr  = (state_q == IDLE) ? addr  : addr_q;
        op_wdata = (state_q == IDLE) ? wdata : wdata_q;
        bad = (op_size == 2'b11) ||
              (op_size == 2'b01 && op_addr[0]) ||
              (op_size == 2'b10 && op_addr[1:0] != 2'b00) ||
              (op_addr[31:2] >= 30'(DEPTH));
        idx      = op_addr[AW+1:2];
        cur      = mem[idx];
        shifted  = cur >> {op_addr[1:0], 3'b000};
        load_val = (op_size == 2'b00) ? {{24{shifted[7] & ~op_unsgn}}, shifted[7:0]} :
                   (op_size == 2'b01) ? {{16{shifted[15] & ~op_unsgn}}, shifted[15:0]} : cur;
        be   = (op_size == 2'b00) ? (4'b0001 << op_addr[1:0]) :
               (op_size == 2'b01) ? (op_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // Replicate store data across lanes; the byte enables pick the target.
        wrep = (op_size == 2'b00) ? {4{op_wdata[7:0]}} :
               (op_size == 2'b01) ? {2{op_wdata[15:0]}} : op_wdata;
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        unsgn_d = unsgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    unsgn_d = unsgn;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = commit;
        rdata_d = commit ? ((bad || op_we) ? 32'd0 : load_val) : rdata_q;
        err_d   = commit ? bad : err_q;
        // Gated by rst so nothing commits while reset is asserted.
        wr_en   = commit && op_we && !bad && rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            unsgn_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            unsgn_q <= unsgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wrep[8*b +: 8];
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-array model.
module tb_dmem_responder;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst3, req0, req3, we, unsgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata0, rdata3;
    logic        ready0, ready3, err0, err3;

    int checks = 0;
    int failures = 0;

    logic [7:0] bmem [2][4*DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst0), .req(req0), .we(we), .size(size), .unsgn(unsgn),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0));

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst3), .req(req3), .we(we), .size(size), .unsgn(unsgn),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3));

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        bit          u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] r;
        bit          e;
    } op_t;

    op_t tbl [15] = '{
        '{1'b1, 2'd2, 1'b0, 32'h20,  32'h0000_0000, 32'h0000_0000, 1'b0},
        '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
        '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0},
        '{1'b1, 2'd0, 1'b0, 32'h21,  32'hFFFF_FF80, 32'h0000_0000, 1'b0},
        '{1'b0, 2'd0, 1'b0, 32'h21,  32'h0,         32'hFFFF_FF80, 1'b0},
        '{1'b0, 2'd0, 1'b1, 32'h21,  32'h0,         32'h0000_0080, 1'b0},
        '{1'b1, 2'd1, 1'b0, 32'h22,  32'hABCD_1234, 32'h0000_0000, 1'b0},
        '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,         32'h1234_8000, 1'b0},
        '{1'b0, 2'd1, 1'b1, 32'h22,  32'h0,         32'h0000_1234, 1'b0},
        '{1'b0, 2'd2, 1'b0, 32'h13,  32'h0,         32'h0000_0000, 1'b1},
        '{1'b1, 2'd1, 1'b0, 32'h31,  32'hFFFF_5A5A, 32'h0000_0000, 1'b1},
        '{1'b0, 2'd1, 1'b0, 32'h23,  32'h0,         32'h0000_0000, 1'b1},
        '{1'b0, 2'd3, 1'b0, 32'h0,   32'h0,         32'h0000_0000, 1'b1},
        '{1'b0, 2'd2, 1'b0, 32'h200, 32'h0,         32'h0000_0000, 1'b1},
        '{1'b1, 2'd0, 1'b0, 32'h200, 32'h0000_00C3, 32'h0000_0000, 1'b1}
    };

    function automatic logic rdy(input bit s3);
        return s3 ? ready3 : ready0;
    endfunction

    // Byte-addressed reference: n consecutive little-endian bytes, then extension.
    function automatic void model(input bit s3, input bit w, input logic [1:0] sz, input bit u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] r, output bit e);
        int n;
        n = 1 << sz;
        r = '0;
        e = (sz == 2'd3) || (a % n != 0) || (a >= 4 * DEPTH);
        if (e) return;
        for (int k = 0; k < n; k++) begin
            if (w) bmem[s3][a + k] = wd[8*k +: 8];
            else   r[8*k +: 8] = bmem[s3][a + k];
        end
        if (!w && n < 4 && !u && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8 * n));
    endfunction

    task automatic run_txn(input bit s3, input bit w, input logic [1:0] sz, input bit u,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output bit e, output int lat, output bit one);
        @(negedge clk);
        we = w; size = sz; unsgn = u; addr = a; wdata = wd;
        if (s3) req3 = 1'b1; else req0 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!rdy(s3) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = s3 ? rdata3 : rdata0;
        e  = s3 ? err3 : err0;
        @(negedge clk);
        req0 = 1'b0; req3 = 1'b0;
        @(posedge clk); #1;
        one = !rdy(s3);
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst3 = 1'b1; req0 = 1'b0; req3 = 1'b0;
        we = 1'b0; size = 2'd0; unsgn = 1'b0; addr = '0; wdata = '0;
        #2; rst0 = 1'b0; rst3 = 1'b0;
        #1;
        checks++;
        if ({ready0, err0, rdata0, ready3, err3, rdata3} !== '0) begin
            failures++;
            $display("FAIL reset_assert ws0 r/e/d=%b/%b/%h ws3 r/e/d=%b/%b/%h need all 0", ready0, err0, rdata0, ready3, err3, rdata3);
        end
        repeat (2) @(negedge clk);
        rst0 = 1'b1; rst3 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ready0, err0, rdata0, ready3, err3, rdata3} !== '0) begin
            failures++;
            $display("FAIL reset_release ws0 r/e/d=%b/%b/%h ws3 r/e/d=%b/%b/%h need all 0", ready0, err0, rdata0, ready3, err3, rdata3);
        end
    endtask

    task automatic test_fill();
        logic [31:0] rd, er, d;
        bit e, ee, one;
        int lat;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                d = $urandom;
                run_txn(s[0], 1'b1, 2'd2, 1'b0, 32'(4 * i), d, rd, e, lat, one);
                model(s[0], 1'b1, 2'd2, 1'b0, 32'(4 * i), d, er, ee);
                checks++;
                if (rd !== er || e !== ee || lat != (s ? 3 : 0) || !one) begin
                    failures++;
                    $display("FAIL fill s%0d w%0d rdata=%h/%h err=%b/%b lat=%0d/%0d single=%b", s, i, rd, er, e, ee, lat, s ? 3 : 0, one);
                end
            end
        end
    endtask

    task automatic test_lanes_and_errors();
        logic [31:0] rd, er;
        bit e, ee, one;
        int lat;
        for (int i = 0; i < 15; i++) begin
            run_txn(1'b0, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, rd, e, lat, one);
            model(1'b0, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, er, ee);
            checks++;
            if (rd !== tbl[i].r || e !== tbl[i].e || lat != 0 || !one) begin
                failures++;
                $display("FAIL lanes_errors op%0d rdata=%h/%h err=%b/%b lat=%0d/0 single=%b", i, rd, tbl[i].r, e, tbl[i].e, lat, one);
            end
        end
        // Failed stores must not have touched words 0x30 or 0x0 (aliased by 0x200).
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = (i == 0) ? 32'h30 : (i == 1) ? 32'h0 : 32'(4 * DEPTH - 4);
            run_txn(1'b0, 1'b0, 2'd2, 1'b0, a, 32'h0, rd, e, lat, one);
            model(1'b0, 1'b0, 2'd2, 1'b0, a, 32'h0, er, ee);
            checks++;
            if (rd !== er || e !== 1'b0 || !one) begin
                failures++;
                $display("FAIL unchanged addr=%h rdata=%h/%h err=%b/0 single=%b", a, rd, er, e, one);
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, er;
        bit e, ee, one;
        int lat;
        logic [7:0] seen;
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, e, lat, one);
        model(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, er, ee);
        checks++;
        if (rd !== er || e !== ee || lat != 3 || !one) begin
            failures++;
            $display("FAIL ws3_latency rdata=%h/%h err=%b/%b lat=%0d/3 single=%b", rd, er, e, ee, lat, one);
        end
        @(negedge clk);
        we = 1'b0; size = 2'd2; unsgn = 1'b0; addr = 32'h44; req3 = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            seen[k-1] = ready3;
        end
        model(1'b1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, er, ee);
        checks++;
        if (seen !== 8'b1000_0100) begin
            failures++;
            $display("FAIL ws3_held_req ready_pattern=%b need 10000100", seen);
        end
        checks++;
        if (rdata3 !== er || err3 !== 1'b0) begin
            failures++;
            $display("FAIL ws3_held_data rdata=%h/%h err=%b/0", rdata3, er, err3);
        end
        @(negedge clk);
        req3 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, er;
        bit e, ee, one, any;
        int lat;
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, e, lat, one);
        @(negedge clk);
        we = 1'b1; size = 2'd2; unsgn = 1'b0; addr = 32'h40; wdata = 32'hAAAA_AAAA; req3 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst3 = 1'b0; req3 = 1'b0;
        #1;
        checks++;
        if ({ready3, err3, rdata3} !== '0) begin
            failures++;
            $display("FAIL midreset_assert ready=%b err=%b rdata=%h need 0/0/0", ready3, err3, rdata3);
        end
        any = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            any |= ready3;
        end
        @(negedge clk);
        rst3 = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            any |= ready3;
        end
        checks++;
        if (any !== 1'b0 || rdata3 !== 32'h0 || err3 !== 1'b0) begin
            failures++;
            $display("FAIL midreset_quiet ready_seen=%b rdata=%h err=%b need 0/0/0", any, rdata3, err3);
        end
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, e, lat, one);
        model(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, er, ee);
        checks++;
        if (rd !== er || e !== 1'b0 || lat != 3 || !one) begin
            failures++;
            $display("FAIL midreset_old_value rdata=%h/%h err=%b/0 lat=%0d/3 single=%b", rd, er, e, lat, one);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, er, a, d;
        logic [1:0] sz;
        bit e, ee, one, u;
        int lat;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                sz = 2'($urandom_range(0, 2));
                a  = 32'($urandom_range(0, 4 * DEPTH - 1)) & ~((32'd1 << sz) - 32'd1);
                d  = $urandom;
                u  = 1'($urandom_range(0, 1));
                for (int p = 0; p < 2; p++) begin
                    run_txn(s[0], p == 0, sz, u, a, d, rd, e, lat, one);
                    model(s[0], p == 0, sz, u, a, d, er, ee);
                    checks++;
                    if (rd !== er || e !== ee || lat != (s ? 3 : 0) || !one) begin
                        failures++;
                        $display("FAIL b2b s%0d pair%0d %s sz=%0d a=%h rdata=%h/%h err=%b/%b lat=%0d single=%b",
                                 s, i, p == 0 ? "st" : "ld", sz, a, rd, er, e, ee, lat, one);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_lanes_and_errors();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
